// File: rtl/display_resultado.sv
// BCD conversion and 4-digit multiplexed common-anode 7-segment display for divider results.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank a tens digit of 0 instead of showing '0').
module display_resultado #(
    parameter int REFRESH_DIV = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cociente,
    input  logic [3:0] resto,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int                 CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [11:0]       coc_sh_r;
    logic [11:0]       res_sh_r;
    logic [1:0]        step_r;
    logic [15:0]       digits_r;
    logic              busy_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        idx_r;
    logic [1:0]        idx_nxt_s;
    logic [3:0]        digit_sel_s;
    logic [6:0]        seg_nxt_s;
    logic [6:0]        seg_r;
    logic [3:0]        an_r;

    // One double-dabble step on {tens, units, binary}: correct BCD nibbles, then shift.
    function automatic logic [11:0] dabble_step(input logic [11:0] v);
        logic [11:0] adj;
        adj = v;
        if (adj[11:8] >= 4'd5) begin
            adj[11:8] = adj[11:8] + 4'd3;
        end
        if (adj[7:4] >= 4'd5) begin
            adj[7:4] = adj[7:4] + 4'd3;
        end
        return {adj[10:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Conversion FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_s = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (step_r == 2'd3) begin
                    state_s = UPDATE;
                end else begin
                    state_s = CONV;
                end
            end
            UPDATE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register and busy flag, busy tracks the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Conversion datapath: capture, four dabble steps, then publish to the digit registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coc_sh_r <= 12'd0;
            res_sh_r <= 12'd0;
            step_r   <= 2'd0;
            digits_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load) begin
                        coc_sh_r <= {8'd0, cociente};
                        res_sh_r <= {8'd0, resto};
                        step_r   <= 2'd0;
                    end
                end
                CONV: begin
                    coc_sh_r <= dabble_step(coc_sh_r);
                    res_sh_r <= dabble_step(res_sh_r);
                    step_r   <= step_r + 2'd1;
                end
                UPDATE: begin
                    digits_r <= {coc_sh_r[11:4], res_sh_r[11:4]};
                end
                default: begin
                    step_r <= 2'd0;
                end
            endcase
        end
    end

    // Digit selected for the slot that starts at the next wrap; odd slots hold tens digits.
    always_comb begin
        idx_nxt_s   = idx_r + 2'd1;
        digit_sel_s = 4'd0;
        case (idx_nxt_s)
            2'd0:    digit_sel_s = digits_r[3:0];
            2'd1:    digit_sel_s = digits_r[7:4];
            2'd2:    digit_sel_s = digits_r[11:8];
            2'd3:    digit_sel_s = digits_r[15:12];
            default: digit_sel_s = 4'd0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_nxt_s[0] && (digit_sel_s == 4'd0)) begin
            seg_nxt_s = 7'h7F;
        end else begin
            seg_nxt_s = decode(digit_sel_s);
        end
`else
        seg_nxt_s = decode(digit_sel_s);
`endif
    end

    // Refresh scan: segments and anodes only change together on a counter wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
            idx_r <= idx_nxt_s;
            an_r  <= ~(4'b0001 << idx_nxt_s);
            seg_r <= seg_nxt_s;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign busy = busy_r;
    assign seg  = seg_r;
    assign an   = an_r;

endmodule
